// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One iteration per clock; a WIDTH-bit conversion takes WIDTH cycles in StConvert,
// followed by a single StDone cycle in which the result registers update.
//
// Ports:
//   clk      - rising-edge clock for all state
//   reset    - synchronous, active-high reset
//   start    - conversion request, accepted in idle or on the done cycle
//   bin      - unsigned binary input, captured on the accept edge
//   bcd      - five packed BCD digits, bcd[3:0] is the ones digit
//   digit_en - per-digit display enable (leading-zero blanking), bit i -> bcd[4i+3:4i]
//   busy     - high while converting
//   done     - one-cycle pulse; bcd/digit_en change only in this cycle
module bin_to_bcd #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic [19:0]      bcd,
  output logic [4:0]       digit_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StDone
  } state_e;

  localparam logic [4:0] CntInit = 5'(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [19:0]      work_q;
  logic [4:0]       cnt_q;
  logic [19:0]      bcd_q;
  logic [4:0]       digit_en_q;
  logic             busy_q;
  logic             done_q;

  logic [19:0]      corr;
  logic [19:0]      work_d;
  logic [WIDTH-1:0] shift_d;
  logic [4:0]       digit_en_d;

  // One double-dabble step: per-nibble add-3 (no inter-nibble carry), then shift the
  // {work, shift} pair left with the binary MSB entering the ones digit.
  always_comb begin
    corr = '0;
    for (int i = 0; i < 5; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end else begin
        corr[4*i +: 4] = work_q[4*i +: 4];
      end
    end
    work_d  = (corr << 1) | 20'(shift_q[WIDTH-1]);
    shift_d = shift_q << 1;
  end

  // Leading-zero blanking: a digit is shown if it or any higher digit is nonzero.
  always_comb begin
    digit_en_d    = '0;
    digit_en_d[4] = |work_d[19:16];
    digit_en_d[3] = digit_en_d[4] | (|work_d[15:12]);
    digit_en_d[2] = digit_en_d[3] | (|work_d[11:8]);
    digit_en_d[1] = digit_en_d[2] | (|work_d[7:4]);
    digit_en_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      digit_en_q <= 5'b00001;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            shift_q <= bin;
            work_q  <= '0;
            cnt_q   <= CntInit;
            busy_q  <= 1'b1;
            state_q <= StConvert;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StConvert: begin
          work_q  <= work_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q - 5'd1;
          // Last iteration: publish the finished value together with the done pulse.
          if (cnt_q == 5'd1) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            bcd_q      <= work_d;
            digit_en_q <= digit_en_d;
            state_q    <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bcd      = bcd_q;
  assign digit_en = digit_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd (WIDTH = 16) against a decimal reference model.
module tb_bin_to_bcd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic [4:0]  digit_en;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_bcd #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .digit_en (digit_en),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: digit i is shown iff the value has more than i decimal digits.
  function automatic logic [4:0] ref_en(input int unsigned v);
    logic [4:0]  e;
    int unsigned p;
    e = 5'b00001;
    p = 10;
    for (int i = 1; i < 5; i++) begin
      e[i] = (v >= p);
      p = p * 10;
    end
    return e;
  endfunction

  // Pulse start with v, then wait (bounded) for done. lat is the cycle index after the
  // accept edge at which done is seen (0 if it never arrived). bin is scrambled after accept.
  task automatic run_conv(input logic [15:0] v, output int lat, output int busy_cnt,
                          output logic [19:0] got, output logic [4:0] got_en);
    int k;
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = 16'($urandom);
    busy_cnt = 0;
    k = 1;
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      tick();
      k++;
    end
    lat    = done ? k : 0;
    got    = bcd;
    got_en = digit_en;
  endtask

  task automatic test_reset();
    // reset and start both high: reset must win
    reset = 1'b1;
    start = 1'b1;
    bin   = 16'd5;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b, required busy=0 done=0", busy, done);
    end
    n_checks++;
    if (bcd !== 20'h00000 || digit_en !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_out: bcd=%h en=%b, required 00000 00001", bcd, digit_en);
    end
    // start accepted on the first edge with reset low
    reset = 1'b0;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_accept: busy=%b, required 1", busy);
    end
    repeat (20) tick();
    n_checks++;
    if (bcd !== 20'h00005) begin
      n_fail++;
      $display("FAIL reset_first_result: bcd=%h, required 00005", bcd);
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    logic [19:0] g;
    logic [4:0]  e;
    run_conv(16'd0, lat, bc, g, e);
    n_checks++;
    if (lat !== 17) begin
      n_fail++;
      $display("FAIL zero_latency: done at cycle N+%0d, required N+17", lat);
    end
    n_checks++;
    if (g !== 20'h00000 || e !== 5'b00001) begin
      n_fail++;
      $display("FAIL zero_value: bcd=%h en=%b, required 00000 00001", g, e);
    end
    tick();
  endtask

  task automatic test_max();
    int lat, bc;
    logic [19:0] g;
    logic [4:0]  e;
    run_conv(16'hFFFF, lat, bc, g, e);
    n_checks++;
    if (g !== 20'h65535 || e !== 5'b11111) begin
      n_fail++;
      $display("FAIL max_value: bcd=%h en=%b, required 65535 11111", g, e);
    end
    n_checks++;
    if (bc !== 16) begin
      n_fail++;
      $display("FAIL max_busy_len: busy %0d cycles, required 16", bc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [19:0] g;
    logic [4:0]  e;
    run_conv(16'd1234, lat, bc, g, e);
    n_checks++;
    if (g !== 20'h01234 || e !== 5'b01111) begin
      n_fail++;
      $display("FAIL b2b_first: bcd=%h en=%b, required 01234 01111", g, e);
    end
    // still in the done cycle: start again immediately
    run_conv(16'd7, lat, bc, g, e);
    n_checks++;
    if (lat !== 17) begin
      n_fail++;
      $display("FAIL b2b_latency: done at cycle N+%0d, required N+17", lat);
    end
    n_checks++;
    if (g !== 20'h00007 || e !== 5'b00001) begin
      n_fail++;
      $display("FAIL b2b_second: bcd=%h en=%b, required 00007 00001", g, e);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    int pulses, first_done;
    logic [19:0] res;
    start = 1'b1;
    bin   = 16'd1234;
    tick();
    start = 1'b0;
    pulses = 0;
    first_done = 0;
    res = '0;
    for (int k = 1; k <= 30; k++) begin
      if (done) begin
        pulses++;
        if (first_done == 0) begin
          first_done = k;
          res = bcd;
        end
      end
      if (k == 5) begin
        start = 1'b1;
        bin   = 16'd999;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    n_checks++;
    if (res !== 20'h01234 || first_done !== 17) begin
      n_fail++;
      $display("FAIL ignored_start_result: bcd=%h at N+%0d, required 01234 at N+17",
               res, first_done);
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL ignored_start_pulses: %0d done pulses, required 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    start = 1'b1;
    bin   = 16'd500;
    tick();
    start = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || bcd !== 20'h00000 || digit_en !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_mid_state: busy=%b bcd=%h en=%b, required 0 00000 00001",
               busy, bcd, digit_en);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) pulses++;
      tick();
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: %0d done pulses, required 0", pulses);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [19:0] g;
    logic [4:0]  e;
    logic [15:0] v;
    logic        nib_ok;
    for (int n = 0; n < 1000; n++) begin
      v = 16'($urandom_range(0, 65535));
      if (n == 0) v = 16'd9999;
      if (n == 1) v = 16'd10000;
      run_conv(v, lat, bc, g, e);
      n_checks++;
      if (g !== ref_bcd(v) || e !== ref_en(v) || lat !== 17) begin
        n_fail++;
        $display("FAIL random_conv: bin=%0d bcd=%h en=%b lat=%0d, required %h %b 17",
                 v, g, e, lat, ref_bcd(v), ref_en(v));
      end
      nib_ok = 1'b1;
      for (int i = 0; i < 5; i++) if (g[4*i +: 4] > 4'd9) nib_ok = 1'b0;
      n_checks++;
      if (nib_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL random_nibble: bcd=%h has a nibble above 9", g);
      end
      // outputs must hold outside the done cycle
      bin = 16'($urandom);
      tick();
      tick();
      n_checks++;
      if (bcd !== ref_bcd(v) || digit_en !== ref_en(v) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL random_hold: bcd=%h en=%b done=%b, required %h %b 0",
                 bcd, digit_en, done, ref_bcd(v), ref_en(v));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) tick();
    test_reset();
    test_zero();
    test_max();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the binary input width; legal range is 4..16.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  conversion request; sampled on the rising edge of clk.
REQ-006 bin  input  WIDTH  unsigned binary value to convert; sampled only when start is accepted.
REQ-007 bcd  output  20  five packed BCD digits.
- bcd[3:0] is the ones digit; bcd[19:16] is the ten-thousands digit.
- Each nibble drives one downstream 4-bit-to-7-segment decoder.
REQ-008 digit_en  output  5  per-digit display enable for leading-zero blanking; bit i corresponds to bcd[4i+3:4i].
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse; bcd and digit_en are updated in the same cycle.

Function
REQ-011 The block SHALL use the shift-and-add-3 (double-dabble) algorithm with a three-state FSM: IDLE, CONVERT, DONE.
REQ-012 IDLE: if start=1 at a clock edge, the block SHALL do all of the following on that edge:
- capture bin into a WIDTH-bit shift register;
- clear the 20-bit working BCD register;
- load the iteration counter with WIDTH;
- go to CONVERT.
Otherwise the block SHALL stay in IDLE.
REQ-013 CONVERT: each cycle the block SHALL perform exactly one iteration:
- add 3 to every working digit that is >= 5;
- shift the {working BCD, shift register} concatenation left by one bit;
- decrement the counter.
REQ-014 CONVERT SHALL go to DONE on the cycle in which the counter reaches zero, after exactly WIDTH iterations.
REQ-015 DONE SHALL last exactly one cycle, with done=1, during which:
- bcd SHALL show the finished working register;
- digit_en SHALL be valid.
REQ-016 From DONE, start=1 SHALL be accepted exactly as in IDLE (back-to-back conversion); otherwise the FSM SHALL return to IDLE.
REQ-017 Latency: if start is accepted at edge N, busy SHALL be high from cycle N+1 through N+WIDTH, and done SHALL be high in cycle N+WIDTH+1.
REQ-018 busy SHALL be high only in CONVERT; done SHALL be high only in DONE.
REQ-019 start asserted while in CONVERT SHALL be ignored, with no effect on the conversion in progress or on its result.
REQ-020 Changes on bin after the accept edge SHALL NOT affect the result.
REQ-021 bcd and digit_en SHALL hold their last values in every cycle other than the update cycle of REQ-015.
REQ-022 digit_en rules:
- bit 0 SHALL always be 1;
- bit i (i>0) SHALL be 1 iff any digit at position >= i is nonzero.
REQ-023 For WIDTH=16, every input 0..65535 SHALL convert exactly; every BCD nibble SHALL be <= 9.
REQ-024 For WIDTH < 16, the unused upper digits SHALL be 0.
REQ-025 The add-3 correction SHALL be applied per nibble, with no carry between nibbles.

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL take these values regardless of start or state:
- FSM = IDLE;
- busy=0, done=0;
- bcd=20'h00000;
- digit_en=5'b00001;
- working registers and counter cleared.
REQ-027 Reset during CONVERT SHALL abort the conversion; no done pulse SHALL follow for that conversion.
REQ-028 With reset and start both high at the same edge, reset SHALL win.
REQ-029 start SHALL first be accepted on the first edge at which reset=0.

Verification
REQ-030 Convert 0, WIDTH=16: bin=0, start pulse -> done in cycle N+17, bcd=20'h00000, digit_en=5'b00001.
REQ-031 Convert 65535: -> bcd=20'h65535, digit_en=5'b11111; bcd=20'h65535 for bin=16'hFFFF; busy high for exactly 16 cycles.
REQ-032 Convert 1234, then back-to-back: bin=1234 -> bcd=20'h01234, digit_en=5'b01111. start held high on the done cycle with bin=7 -> next done 17 cycles later, bcd=20'h00007, digit_en=5'b00001.
REQ-033 Ignored start: start 1234; at cycle N+5 pulse start with bin=999 -> result 20'h01234; exactly one done pulse.
REQ-034 Reset mid-conversion: start 500; assert reset at cycle N+8 for 1 cycle -> next cycle busy=0, bcd=0, digit_en=5'b00001; no done pulse within 20 cycles.
REQ-035 Randomized check: 1000 random 16-bit values -> each bcd digit decoded equals the reference decimal value; all nibbles <= 9.
